// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types : shared type definitions for the cache/memory subsystem.
// Revision    : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter : round-robin arbiter sharing one physical memory port
//                 between the I-cache and the D-cache.
// Revision      : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              prefer_i_q, prefer_i_d;

  logic              d_req;
  logic              grant_d;
  logic              serving;

  assign d_req   = d_read | d_write;
  // D wins unless I is also asking and it is I's turn.
  assign grant_d = d_req && (!i_read || !prefer_i_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      prefer_i_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      prefer_i_q <= prefer_i_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    prefer_i_d = prefer_i_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d    = SERVE_D;
          addr_d     = d_address;
          wdata_d    = d_wdata;
          write_d    = d_write;
          prefer_i_d = 1'b1;
        end else if (i_read) begin
          state_d    = SERVE_I;
          addr_d     = i_address;
          write_d    = 1'b0;
          prefer_i_d = 1'b0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    serving    = (state_q == SERVE_I) || (state_q == SERVE_D);
    pmem_read  = serving && !write_q;
    pmem_write = serving && write_q;
    i_resp     = (state_q == SERVE_I) && pmem_resp;
    d_resp     = (state_q == SERVE_D) && pmem_resp;
  end

  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_arbiter : directed self-checking bench for cache_arbiter.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read, d_read, d_write;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              i_resp, d_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: answers LAT cycles after a request first appears, data derived from address.
  int   mem_lat  = 1;
  int   mem_cnt  = 0;
  bit   mem_auto = 1'b1;
  logic auto_resp = 1'b0;
  logic man_resp  = 1'b0;
  assign pmem_resp = mem_auto ? auto_resp : man_resp;

  always @(negedge clk) begin
    auto_resp  = 1'b0;
    pmem_rdata = {8{pmem_address ^ 32'hDEAD_0000}};
    if (pmem_read || pmem_write) begin
      if (mem_cnt >= mem_lat) begin
        auto_resp = 1'b1;
        mem_cnt   = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Transaction-level reference: at most one outstanding memory transaction.
  bit                m_active   = 1'b0;
  bit                m_d        = 1'b0;
  bit                m_wr       = 1'b0;
  bit                m_prefer_i = 1'b0;
  logic [ADDR_W-1:0] m_addr     = '0;
  logic [LINE_W-1:0] m_wdata    = '0;
  bit                grant_log[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active   = 1'b0;
      m_prefer_i = 1'b0;
    end else if (m_active) begin
      if (pmem_resp) m_active = 1'b0;
    end else if (i_read || d_read || d_write) begin
      bit pick_d;
      pick_d     = (d_read || d_write) && !(i_read && m_prefer_i);
      m_active   = 1'b1;
      m_d        = pick_d;
      m_wr       = pick_d && d_write;
      m_addr     = pick_d ? d_address : i_address;
      m_wdata    = d_wdata;
      m_prefer_i = pick_d;
      grant_log.push_back(pick_d);
    end
  end

  logic [ADDR_W-1:0] addr_log[$];
  int                gap_log[$];
  bit                prev_busy = 1'b0;
  int                idle_cnt  = 0;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      chk("pmem_read", pmem_read, m_active && !m_wr);
      chk("pmem_write", pmem_write, m_active && m_wr);
      chk("i_resp", i_resp, m_active && !m_d && pmem_resp);
      chk("d_resp", d_resp, m_active && m_d && pmem_resp);
      if (m_active) chk("pmem_address", pmem_address, m_addr);
      if (m_active && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
      if (i_resp) chk("i_rdata", i_rdata, pmem_rdata);
      if (d_resp) chk("d_rdata", d_rdata, pmem_rdata);
      if ((pmem_read || pmem_write) && !prev_busy) begin
        addr_log.push_back(pmem_address);
        gap_log.push_back(idle_cnt);
        idle_cnt = 0;
      end else if (!(pmem_read || pmem_write)) begin
        idle_cnt++;
      end
      prev_busy = pmem_read || pmem_write;
    end else begin
      prev_busy = 1'b0;
      idle_cnt  = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    man_resp = 1'b0; mem_auto = 1'b1;
    repeat (2) @(negedge clk);
    addr_log.delete(); gap_log.delete(); grant_log.delete();
    rst = 1'b1;
  endtask

  // Returns at the sample point of the response cycle (or after the bound expires).
  task automatic wait_resp(input bit is_d, output bit got);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk); #4;
      got = is_d ? d_resp : i_resp;
    end
  endtask

  task automatic i_client(input logic [ADDR_W-1:0] base, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      i_read    = 1'b1;
      i_address = base + ADDR_W'(k) * 32'h40;
      wait_resp(1'b0, got);
      chk("i_client_resp_seen", got, 1);
      @(negedge clk);
    end
    i_read = 1'b0;
  endtask

  task automatic d_client(input logic [ADDR_W-1:0] base, input int n);
    bit got;
    for (int k = 0; k < n; k++) begin
      d_read    = 1'b1;
      d_write   = 1'b0;
      d_address = base + ADDR_W'(k) * 32'h40;
      wait_resp(1'b1, got);
      chk("d_client_resp_seen", got, 1);
      @(negedge clk);
    end
    d_read = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp4[4];
    int cyc;
    bit got;
    exp4 = '{32'h2000, 32'h1000, 32'h2040, 32'h1040};

    // Reset state
    do_reset();
    #4;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    chk("rst_pmem_address", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);

    // I only, memory answers 3 cycles after the request appears
    @(negedge clk);
    mem_lat = 3;
    i_read = 1'b1; i_address = 32'h0000_1000;
    @(negedge clk); #4;
    chk("t1_pmem_read_c1", pmem_read, 1);
    chk("t1_pmem_addr_c1", pmem_address, 32'h1000);
    cyc = 1; got = i_resp;
    while (!got && cyc < 20) begin
      @(negedge clk); #4;
      cyc++;
      got = i_resp;
    end
    chk("t1_resp_cycle", cyc, 4);
    chk("t1_i_rdata", i_rdata, {8{32'hDEAD1000}});
    @(negedge clk);
    i_read = 1'b0;

    // Simultaneous requests straight after reset: D first
    do_reset();
    mem_lat = 1;
    fork
      i_client(32'h100, 1);
      d_client(32'h200, 1);
    join
    repeat (2) @(negedge clk);
    chk("t2_txn_count", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("t2_first_addr", addr_log[0], 32'h200);
      chk("t2_second_addr", addr_log[1], 32'h100);
      chk("t2_idle_gap", gap_log[1], 1);
    end
    chk("t2_model_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t2_model_first_d", grant_log[0], 1);
      chk("t2_model_second_i", grant_log[1], 0);
    end

    // D writeback with pattern data
    mem_lat = 2;
    d_write = 1'b1; d_read = 1'b0; d_address = 32'h80; d_wdata = {32{8'hA5}};
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk); #4;
      cyc++;
      chk("t3_pmem_write", pmem_write, 1);
      chk("t3_pmem_read", pmem_read, 0);
      chk("t3_pmem_addr", pmem_address, 32'h80);
      chk("t3_pmem_wdata", pmem_wdata, {32{8'hA5}});
      got = d_resp;
    end
    chk("t3_d_resp_seen", got, 1);
    @(negedge clk);
    d_write = 1'b0;
    #4;
    chk("t3_d_resp_one_cycle", d_resp, 0);

    // Continuous I and D over four transactions
    do_reset();
    mem_lat = 1;
    fork
      i_client(32'h1000, 2);
      d_client(32'h2000, 2);
    join
    repeat (2) @(negedge clk);
    chk("t4_txn_count", addr_log.size(), 4);
    if (addr_log.size() == 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("t4_addr_%0d", k), addr_log[k], exp4[k]);
      for (int k = 1; k < 4; k++) chk($sformatf("t4_gap_%0d", k), gap_log[k], 1);
    end

    // Reset while serving I, then a late memory response
    do_reset();
    mem_auto = 1'b0;
    i_read = 1'b1; i_address = 32'h300;
    @(negedge clk);
    @(negedge clk); #2;
    chk("t5_pmem_read_before_rst", pmem_read, 1);
    rst = 1'b0;
    #1;
    chk("t5_pmem_read_async", pmem_read, 0);
    chk("t5_i_resp_in_rst", i_resp, 0);
    i_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    man_resp = 1'b1;
    #4;
    chk("t5_late_i_resp", i_resp, 0);
    chk("t5_late_pmem_read", pmem_read, 0);
    @(negedge clk);
    man_resp = 1'b0;
    mem_auto = 1'b1;

    // Read and write together is a write; request dropped early still completes
    mem_lat = 3;
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h400; d_wdata = {8{32'h1234_5678}};
    @(negedge clk); #4;
    chk("t6_pmem_write", pmem_write, 1);
    chk("t6_pmem_read", pmem_read, 0);
    @(negedge clk);
    d_read = 1'b0; d_write = 1'b0;
    wait_resp(1'b1, got);
    chk("t6_dropped_resp_seen", got, 1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, physical address width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have ports i_read input 1 and i_address input ADDR_W: I-cache line-fill request.
REQ-006 SHALL have ports i_rdata output LINE_W and i_resp output 1: I-cache fill data and one-cycle completion.
REQ-007 SHALL have ports d_read input 1, d_write input 1, d_address input ADDR_W and d_wdata input LINE_W: D-cache fill/writeback request.
REQ-008 SHALL have ports d_rdata output LINE_W and d_resp output 1: D-cache fill data and one-cycle completion.
REQ-009 SHALL have ports pmem_read output 1, pmem_write output 1, pmem_address output ADDR_W and pmem_wdata output LINE_W: physical memory request.
REQ-010 SHALL have ports pmem_rdata input LINE_W and pmem_resp input 1: physical memory data and completion.

Function
REQ-011 SHALL implement FSM states IDLE, SERVE_I and SERVE_D.
REQ-012 In IDLE with only i_read high, SHALL latch i_address and go to SERVE_I next edge.
REQ-013 In IDLE with only d_read or d_write high, SHALL latch d_address, d_wdata and direction, and go to SERVE_D next edge.
REQ-014 In IDLE with both clients requesting, SHALL grant round-robin: the client not granted last wins; after reset, D wins.
REQ-015 In SERVE_x, SHALL drive pmem_read or pmem_write (never both) from the latched direction, with pmem_address and pmem_wdata from latched registers, held stable until pmem_resp.
REQ-016 On pmem_resp in SERVE_x, SHALL pulse x_resp high the same cycle, pass pmem_rdata to x_rdata combinationally, and return to IDLE next edge.
REQ-017 SHALL never assert the non-granted client's resp; i_rdata and d_rdata MAY mirror pmem_rdata at all times.
REQ-018 In IDLE, pmem_read, pmem_write, i_resp and d_resp SHALL be 0.
REQ-019 Request-to-pmem latency SHALL be 1 cycle, and there SHALL be exactly one IDLE cycle between back-to-back transactions.
REQ-020 If d_read and d_write are both high, SHALL treat the request as a write (writeback-first).
REQ-021 pmem_resp arriving in IDLE SHALL be ignored.
REQ-022 Clients hold requests until resp; a request dropped early SHALL still complete to memory, and the resp pulse is delivered regardless.
REQ-023 SHALL support address and data widths as parameterised, with no truncation of address bits.

Reset
REQ-024 On rst=0, SHALL go to IDLE immediately, deassert all pmem and resp outputs, clear latched address/data to 0, and set the round-robin pointer to favour D.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no resp pulse; a later pmem_resp SHALL be ignored per REQ-021.

Structure
REQ-026 SHALL place the FSM state enum (arb_state_t) in the shared rv32i_types package.
REQ-027 SHALL be a single module with no sub-modules; the latched request register and the pointer are local flops.

Verification
REQ-028 I only: i_read=1, i_address=0x0000_1000; memory responds 3 cycles after pmem_read -> pmem_read=1 with pmem_address=0x1000 in cycle 1, i_resp=1 with i_rdata=pmem_rdata in cycle 4, d_resp=0 throughout.
REQ-029 Simultaneous requests after reset, i_read with 0x100 and d_read with 0x200 -> D served first at 0x200, one IDLE cycle, then I served at 0x100.
REQ-030 D write with d_address=0x80 and d_wdata pattern 0xA5 repeated -> pmem_write=1 and pmem_read=0, with pmem_wdata equal to the pattern and stable until pmem_resp, then d_resp pulse of exactly one cycle.
REQ-031 Continuous I and D requests over 4 transactions -> grants alternate D, I, D, I, and no client waits more than one transaction.
REQ-032 rst=0 asserted while in SERVE_I before pmem_resp -> pmem_read=0 immediately (asynchronous); a late pmem_resp produces no i_resp.
REQ-033 d_read and d_write both 1 -> pmem_write=1 and pmem_read=0.
